// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential double-dabble (shift-add-3) converter from unsigned binary to
//   packed BCD. Feeds the character-LCD writer, which samples bcd at any time,
//   so the result registers only change in the single DONE cycle.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     Adds the blank output, a leading-zero mask updated together with bcd.
//
// Parameters
//   BIN_W   width of the binary input (>= 2)
//   DIGITS  number of BCD digits produced; digit 0 is the units digit
//
// Ports
//   clk       system clock, all state changes on posedge
//   rst       asynchronous, active-high reset
//   start     conversion request, only honoured in IDLE
//   bin       binary value, captured on the accepted start edge
//   busy      high while shifting
//   valid     one-cycle pulse when bcd/overflow (and blank) update
//   bcd       packed BCD result, bcd[3:0] = units
//   overflow  input exceeded 10^DIGITS-1; bcd holds value mod 10^DIGITS
//   blank     (LEADING_ZERO_BLANK_EN only) blank[i]=1 when digit i and all
//             higher digits are zero, i >= 1; blank[0] is always 0
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [BIN_W-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf_flag;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_bcd;
    logic               r_overflow;
    logic               r_valid;
    logic [ACC_W-1:0]   w_acc_adj;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: defaults are assigned first so no path leaves a variable unwritten,
    // which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (r_cnt == '0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Add-3 correction: any digit >= 5 would become >= 10 after doubling, so
    // pre-add 3 to push the excess into the next digit on the shift. 4-bit add,
    // carry-out is impossible since the largest legal digit is 9 -> 12.
    // -------------------------------------------------------------------------
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  w_blank;
    logic               w_zero_run;

    // Walk down from the top digit; a digit is blanked only while every digit
    // above it (and itself) is zero. Units digit is never blanked.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (r_acc[4*i +: 4] == 4'd0);
            w_blank[i] = w_zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank <= '0;
        end else if (r_state == S_DONE) begin
            r_blank <= w_blank;
        end
    end

    assign blank = r_blank;
`endif

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin      <= '0;
            r_acc      <= '0;
            r_ovf_flag <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin      <= bin;
                        r_acc      <= '0;
                        r_ovf_flag <= 1'b0;
                        r_cnt      <= CNT_W'(BIN_W - 1);
                    end
                end
                S_SHIFT: begin
                    r_acc <= {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    // Bit leaving the top digit means the value no longer fits;
                    // the lower digits stay correct modulo 10^DIGITS.
                    if (w_acc_adj[ACC_W-1]) begin
                        r_ovf_flag <= 1'b1;
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_bcd      <= r_acc;
                    r_overflow <= r_ovf_flag;
                    r_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == S_SHIFT);
    assign valid    = r_valid;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq. Two instances: DIGITS=3 (main) and
//   DIGITS=2 (overflow behaviour). Stimulus driven and outputs sampled on the
//   falling clock edge. Blank checks compile only with LEADING_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start3;
    logic [7:0]  bin3;
    logic        busy3, valid3, ovf3;
    logic [11:0] bcd3;

    logic        start2;
    logic [7:0]  bin2;
    logic        busy2, valid2, ovf2;
    logic [7:0]  bcd2;

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]  blank3;
    logic [1:0]  blank2;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .start    (start3),
        .bin      (bin3),
        .busy     (busy3),
        .valid    (valid3),
        .bcd      (bcd3),
        .overflow (ovf3)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank    (blank3)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .bin      (bin2),
        .busy     (busy2),
        .valid    (valid2),
        .bcd      (bcd2),
        .overflow (ovf2)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank    (blank2)
`endif
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Starts one conversion from a falling edge and returns at the falling edge
    // where valid is seen. Calling it again immediately gives back-to-back starts.
    task automatic run(input bit sel, input logic [7:0] v,
                       output logic [11:0] r_bcd, output logic r_ovf,
                       output logic [2:0] r_blank, output int lat,
                       output int nbusy, output bit ok);
        ok      = 1'b0;
        lat     = 0;
        nbusy   = 0;
        r_bcd   = '0;
        r_ovf   = 1'b0;
        r_blank = '0;
        if (sel) begin
            start2 = 1'b1;
            bin2   = v;
        end else begin
            start3 = 1'b1;
            bin3   = v;
        end
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start3 = 1'b0;
            start2 = 1'b0;
            if (sel ? busy2 : busy3) nbusy++;
            if (sel ? valid2 : valid3) begin
                ok    = 1'b1;
                lat   = cyc - 1;
                r_bcd = sel ? {4'h0, bcd2} : bcd3;
                r_ovf = sel ? ovf2 : ovf3;
`ifdef LEADING_ZERO_BLANK_EN
                r_blank = sel ? {1'b0, blank2} : blank3;
`endif
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_bad++;
            $display("FAIL timeout: no valid for bin=%0d got=none expected=valid", v);
        end
    endtask

    initial begin
        logic [11:0] g_bcd;
        logic [11:0] exp_bcd;
        logic        g_ovf;
        logic [2:0]  g_blank;
        int          lat, nbusy, nvalid, nib_bad, nsweep;
        bit          ok;

        vecs[0] = '{8'd45,  12'h045, 1'b0, 3'b100};
        vecs[1] = '{8'd255, 12'h255, 1'b0, 3'b000};
        vecs[2] = '{8'd0,   12'h000, 1'b0, 3'b110};
        vecs[3] = '{8'd7,   12'h007, 1'b0, 3'b110};
        vecs[4] = '{8'd10,  12'h010, 1'b0, 3'b100};
        vecs[5] = '{8'd100, 12'h100, 1'b0, 3'b000};
        vecs[6] = '{8'd99,  12'h099, 1'b0, 3'b100};
        vecs[7] = '{8'd200, 12'h200, 1'b0, 3'b000};

        rst    = 1'b1;
        start3 = 1'b0;
        start2 = 1'b0;
        bin3   = '0;
        bin2   = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy",  {31'd0, busy3},  32'd0);
        check("rst_valid", {31'd0, valid3}, 32'd0);
        check("rst_bcd",   {20'd0, bcd3},   32'd0);
        check("rst_ovf",   {31'd0, ovf3},   32'd0);
        check("rst_bcd2",  {24'd0, bcd2},   32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        check("rst_blank", {29'd0, blank3}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Table-driven directed conversions on the 3-digit instance
        for (int i = 0; i < 8; i++) begin
            run(1'b0, vecs[i].bin, g_bcd, g_ovf, g_blank, lat, nbusy, ok);
            if (ok) begin
                check($sformatf("tbl%0d_bcd", i), {20'd0, g_bcd}, {20'd0, vecs[i].bcd});
                check($sformatf("tbl%0d_ovf", i), {31'd0, g_ovf}, {31'd0, vecs[i].ovf});
`ifdef LEADING_ZERO_BLANK_EN
                check($sformatf("tbl%0d_blank", i), {29'd0, g_blank}, {29'd0, vecs[i].blank});
`endif
                if (i == 0) begin
                    check("latency_edges", lat, 9);
                    check("busy_cycles", nbusy, 8);
                end
            end
        end

        // valid is a single-cycle pulse and results hold while idle
        @(negedge clk);
        check("valid_pulse_width", {31'd0, valid3}, 32'd0);
        repeat (5) @(negedge clk);
        check("hold_bcd",   {20'd0, bcd3},   {20'd0, 12'h200});
        check("hold_valid", {31'd0, valid3}, 32'd0);

        // Two-digit instance: overflow then recovery
        run(1'b1, 8'd200, g_bcd, g_ovf, g_blank, lat, nbusy, ok);
        if (ok) begin
            check("d2_200_bcd", {20'd0, g_bcd}, 32'h00);
            check("d2_200_ovf", {31'd0, g_ovf}, 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
            check("d2_200_blank", {29'd0, g_blank}, 32'b10);
`endif
        end
        run(1'b1, 8'd99, g_bcd, g_ovf, g_blank, lat, nbusy, ok);
        if (ok) begin
            check("d2_99_bcd", {20'd0, g_bcd}, 32'h99);
            check("d2_99_ovf", {31'd0, g_ovf}, 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
            check("d2_99_blank", {29'd0, g_blank}, 32'b00);
`endif
        end

        // start held every cycle of a bin=37 conversion while bin moves to 99
        start3 = 1'b1;
        bin3   = 8'd37;
        nvalid = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (valid3) begin
                nvalid++;
                if (nvalid == 1) begin
                    check("ignore_first_at", c, 10);
                    check("ignore_first_bcd", {20'd0, bcd3}, {20'd0, 12'h037});
                end else begin
                    check("ignore_second_at", c, 20);
                    check("ignore_second_bcd", {20'd0, bcd3}, {20'd0, 12'h099});
                end
            end
            bin3   = 8'd99;
            start3 = (c < 20);
        end
        check("ignore_valid_count", nvalid, 2);

        // Reset in the 4th SHIFT cycle of bin=128
        start3 = 1'b1;
        bin3   = 8'd128;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start3 = 1'b0;
        end
        check("abort_busy_before", {31'd0, busy3}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",  {31'd0, busy3},  32'd0);
        check("abort_bcd",   {20'd0, bcd3},   32'd0);
        check("abort_valid", {31'd0, valid3}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid3) nvalid++;
        end
        check("abort_no_valid", nvalid, 0);
        check("abort_bcd_after", {20'd0, bcd3}, 32'd0);
        run(1'b0, 8'd7, g_bcd, g_ovf, g_blank, lat, nbusy, ok);
        if (ok) begin
            check("after_abort_bcd", {20'd0, g_bcd}, {20'd0, 12'h007});
        end

        // Exhaustive back-to-back sweep against a decimal reference
        nsweep  = 0;
        nib_bad = 0;
        for (int v = 0; v < 256; v++) begin
            run(1'b0, 8'(v), g_bcd, g_ovf, g_blank, lat, nbusy, ok);
            if (ok) begin
                nsweep++;
                exp_bcd[11:8] = 4'(v / 100);
                exp_bcd[7:4]  = 4'((v / 10) % 10);
                exp_bcd[3:0]  = 4'(v % 10);
                check($sformatf("sweep_%0d", v), {20'd0, g_bcd}, {20'd0, exp_bcd});
                for (int d = 0; d < 3; d++) begin
                    if (g_bcd[4*d +: 4] > 4'd9) nib_bad++;
                end
            end
        end
        check("sweep_nibble_range", nib_bad, 0);
        check("sweep_valid_count", nsweep, 256);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble (shift-add-3) converter from unsigned binary to packed BCD digits.
- Sits directly upstream of the HD44780 character-LCD writer. It supplies the tens/units (and hundreds) digits that the writer maps to ASCII 0x30–0x39.
- Uses a start/valid handshake. The result is held stable between conversions so the LCD writer can sample it at any time.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD digits produced; digit 0 is the units digit.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- valid  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  4*DIGITS  packed BCD; bcd[3:0] = units, bcd[7:4] = tens, etc.
- overflow  output  1  value exceeded 10^DIGITS−1; updated with valid.
- blank  output  DIGITS  leading-zero mask; present only with LEADING_ZERO_BLANK_EN.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: state=IDLE, busy=0, valid=0, bcd=0, overflow=0, blank=0. Internal shift register and bit counter are cleared.
- Reset mid-conversion: abort immediately. No valid is produced, and outputs return to their reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: capture bin into the shift register, clear the BCD accumulator and the overflow flag, load cnt=BIN_W−1, busy=1, go to SHIFT.
- IDLE, start=0: stay in IDLE; outputs hold.
- SHIFT, each cycle:
  - For every digit ≥5, add 3 (4-bit, no carry out).
  - Shift {accumulator, binreg} left by one.
  - Bit shifted out of the top digit = 1 → set the sticky overflow flag.
  - cnt==0 → go to DONE; otherwise cnt−1.
- DONE: drive bcd ← accumulator, overflow ← flag, valid=1 for this single cycle, busy=0, return to IDLE.
- Latency: start accepted at edge N; busy high from edge N to N+BIN_W; valid high in the cycle following edge N+BIN_W+1. BIN_W=8 gives 9 cycles start→valid.
- Throughput: a new start is accepted in the IDLE cycle immediately after DONE. One conversion per BIN_W+2 cycles.
- start while busy or in DONE: ignored, not queued. bin changes after capture have no effect.
- bcd and overflow hold their last values until the next DONE. They are never partially updated during SHIFT.
- Overflow result: bcd holds the low DIGITS digits of the true decimal value (modulo 10^DIGITS) and overflow=1.
- Input 0: bcd=0, overflow=0.
- Maximum input (2^BIN_W−1): exact when it fits in DIGITS digits.
- Each bcd nibble is always in the range 0–9.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - The blank port exists and is updated together with bcd in DONE.
  - blank[i]=1 when digit i and all higher digits are zero, for i≥1.
  - blank[0] is always 0, so the value 0 shows a single "0".
  - Reset value of blank is 0.
  - The LCD writer substitutes 0x20 (space) for blanked digits.
- Not defined: the blank port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then start with bin=45 → busy for 8 cycles, valid pulse 9 cycles after start, bcd=12'h045, overflow=0; blank=3'b100 if the feature is enabled.
- bin=255 → bcd=12'h255, overflow=0. Next, bin=0 → bcd=12'h000, blank=3'b110.
- DIGITS=2, bin=200 → bcd=8'h00, overflow=1. Then bin=99 → bcd=8'h99, overflow=0.
- Pulse start at every cycle of a bin=37 conversion while bin toggles to 99 → exactly one valid, bcd=12'h037. The next start is accepted in the first IDLE cycle, and the second conversion yields the then-present bin.
- Assert rst in the 4th SHIFT cycle of bin=128, release, then start bin=7:
  - The aborted conversion gives no valid, and bcd=0 after reset.
  - The bin=7 conversion gives bcd=12'h007.
- Exhaustive 0–255 sweep with back-to-back starts → every result matches the reference decimal conversion, no nibble exceeds 9, and valid count equals 256.
